float_fifo: RTL

- Parametrised successor to the single-entry float register: a FIFO of IEEE-style floats with configurable exponent width, mantissa width and depth.
- Optional flush-to-zero of subnormals on write.
- Per-entry classification flags are presented with the head entry.
- Sits between float producers and consumers as a ready/valid buffer in float_pkg-based datapaths.

---
 rtl/float_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/float_fifo.sv
// float_fifo: ready/valid FIFO of packed IEEE-style floats {sign, biased_exp, mantissa}.
//
// Storage is first-word-fall-through. The head entry appears on rdata_o and is
// classified combinationally into zero / subnormal / inf / NaN flags. With
// FlushSubnormal set, subnormal writes are stored as a zero of the same sign, and
// ftz_pulse_o reports each such flush one cycle after the write is accepted.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset (control state only)
//   wvalid_i / wready_o     write handshake; wready_o = !full, independent of rready_i
//   wdata_i                 write data {sign, exp[ExpWidth-1:0], mant[MantWidth-1:0]}
//   rvalid_o / rready_i     read handshake; rvalid_o = !empty
//   rdata_o                 head entry
//   is_zero_o, is_subnormal_o, is_inf_o, is_nan_o   head classification
//   count_o                 occupancy, 0..Depth
//   ftz_pulse_o             previous cycle's accepted write was flushed to zero
module float_fifo #(
  parameter int unsigned ExpWidth       = 8,
  parameter int unsigned MantWidth      = 23,
  parameter int unsigned Depth          = 4,
  parameter bit          FlushSubnormal = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wvalid_i,
  output logic                             wready_o,
  input  logic [ExpWidth+MantWidth:0]      wdata_i,
  output logic                             rvalid_o,
  input  logic                             rready_i,
  output logic [ExpWidth+MantWidth:0]      rdata_o,
  output logic                             is_zero_o,
  output logic                             is_subnormal_o,
  output logic                             is_inf_o,
  output logic                             is_nan_o,
  output logic [$clog2(Depth+1)-1:0]       count_o,
  output logic                             ftz_pulse_o
);

  localparam int unsigned W    = 1 + ExpWidth + MantWidth;
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  function automatic logic [ExpWidth-1:0] exp_of(input logic [W-1:0] f);
    exp_of = f[W-2:MantWidth];
  endfunction

  function automatic logic [MantWidth-1:0] mant_of(input logic [W-1:0] f);
    mant_of = f[MantWidth-1:0];
  endfunction

  function automatic logic is_subnormal(input logic [W-1:0] f);
    is_subnormal = (exp_of(f) == '0) && (mant_of(f) != '0);
  endfunction

  // Subnormals collapse to a signed zero; every other encoding (including inf
  // and NaN payloads) passes through untouched.
  function automatic logic [W-1:0] flush_subnormal(input logic [W-1:0] f);
    if (FlushSubnormal && is_subnormal(f)) begin
      flush_subnormal = {f[W-1], {(W-1){1'b0}}};
    end else begin
      flush_subnormal = f;
    end
  endfunction

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    next_ptr = (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [W-1:0]    mem_q [Depth];
  logic [W-1:0]    mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ftz_pulse_q, ftz_pulse_d;

  logic            push;
  logic            pop;
  logic [W-1:0]    store_data;
  logic [ExpWidth-1:0]  head_exp;
  logic [MantWidth-1:0] head_mant;

  assign wready_o = (count_q != FullCnt);
  assign rvalid_o = (count_q != '0);
  assign push     = wvalid_i & wready_o;
  assign pop      = rvalid_o & rready_i;

  assign store_data = flush_subnormal(wdata_i);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ftz_pulse_d = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q] = store_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
      ftz_pulse_d     = FlushSubnormal && is_subnormal(wdata_i);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is never cleared; resetting the pointers and count is enough to
  // discard its contents.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ftz_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ftz_pulse_q <= ftz_pulse_d;
    end
  end

  // Head decode: rdata_o comes straight from storage, so wdata_i never
  // reaches it combinationally.
  assign rdata_o     = mem_q[rd_ptr_q];
  assign head_exp    = exp_of(rdata_o);
  assign head_mant   = mant_of(rdata_o);

  assign is_zero_o      = (head_exp == '0) && (head_mant == '0);
  assign is_subnormal_o = (head_exp == '0) && (head_mant != '0);
  assign is_inf_o       = (&head_exp) && (head_mant == '0);
  assign is_nan_o       = (&head_exp) && (head_mant != '0);

  assign count_o     = count_q;
  assign ftz_pulse_o = ftz_pulse_q;

endmodule
